// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } ifu_state_t;

  localparam int          INSTR_W            = 32;
  localparam int          PC_INC             = 4;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam int          DEFAULT_IMEM_BYTES = 128;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] p);
    return p & ~32'd3;
  endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter: register, +4 adder, redirect alignment and next-PC priority mux.
module ifu_pc_reg
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  input  logic        advance,
  output logic [31:0] pc
);

  logic [31:0] pc_next;

  // Redirect outranks advance; with neither, the PC holds.
  always_comb begin
    pc_next = pc;
    if (redir_valid) begin
      pc_next = align_pc(redir_pc);
    end else if (advance) begin
      pc_next = pc + 32'(PC_INC);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, IF output register with valid/ready toward decode, handshake counter.
// Optional bounds fault with HALT state is enabled by defining IFU_BOUNDS_CHECK_EN.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          IMEM_ADDR_W = 7,
  parameter int          IMEM_BYTES  = DEFAULT_IMEM_BYTES,
  parameter int          CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0]     imem_data,
  input  logic                   redir_valid,
  input  logic [31:0]            redir_pc,
  output logic                   if_valid,
  output logic [INSTR_W-1:0]     if_instr,
  output logic [31:0]            if_pc,
  input  logic                   id_ready,
  output logic                   halted,
  output logic [CNT_W-1:0]       fetch_cnt
);

  // Handshake: the IF register transfers to decode on an edge where
  // if_valid && id_ready. The register may be refilled whenever it is empty
  // or being drained (adv); otherwise it and the PC hold.
  logic        adv;
  logic        fetch;
  logic        bounds_fault;
  logic [31:0] pc;
  ifu_state_t  state;

  assign adv       = !if_valid || id_ready;
  assign imem_addr = pc[IMEM_ADDR_W-1:0];

`ifdef IFU_BOUNDS_CHECK_EN
  ifu_state_t state_next;

  assign bounds_fault = (pc >= 32'(IMEM_BYTES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Only a redirect (or reset) leaves HALT.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (!redir_valid && adv && bounds_fault) begin
          state_next = HALT;
        end
      end
      HALT: begin
        if (redir_valid) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end
`else
  assign bounds_fault = 1'b0;
  assign state        = RUN;
`endif

  assign halted = (state == HALT);
  assign fetch  = !redir_valid && adv && (state == RUN) && !bounds_fault;

  ifu_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .reset       (reset),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .advance     (fetch),
    .pc          (pc)
  );

  // A handshake coinciding with a redirect is still counted before the flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_valid  <= 1'b0;
      if_instr  <= '0;
      if_pc     <= '0;
      fetch_cnt <= '0;
    end else begin
      if (if_valid && id_ready) begin
        fetch_cnt <= fetch_cnt + CNT_W'(1);
      end
      if (redir_valid) begin
        if_valid <= 1'b0;
      end else if (fetch) begin
        if_valid <= 1'b1;
        if_instr <= imem_data;
        if_pc    <= pc;
      end else if (adv) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: run, stall, redirects, async reset, bounds.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic [6:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        halted;
  logic [15:0] fetch_cnt;

  logic [31:0] mem [0:31];
  logic [63:0] exp_q [$];
  logic [63:0] got;
  int          vectors;
  int          miscompares;

  instr_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .id_ready    (id_ready),
    .halted      (halted),
    .fetch_cnt   (fetch_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign imem_data = mem[imem_addr[6:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input logic [31:0] p);
    logic [4:0] w;
    w = p[6:2];
    exp_q.push_back({p, mem[w]});
  endtask

  task automatic test_reset();
    reset = 1'b1; id_ready = 1'b0; redir_valid = 1'b0; redir_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({if_valid, if_instr, if_pc, halted, fetch_cnt, imem_addr} !== {1'b0, 32'h0, 32'h0, 1'b0, 16'h0, 7'h0}) begin
      miscompares++;
      $display("FAIL reset_state: got v=%0b instr=%h pc=%h halt=%0b cnt=%0d addr=%h, want all zero",
               if_valid, if_instr, if_pc, halted, fetch_cnt, imem_addr);
    end
    reset = 1'b0;
    id_ready = 1'b1;
  endtask

  task automatic test_run_and_stall();
    for (int k = 0; k < 3; k++) begin
      push_fetch(32'(4 * k));
      tick();
      got = exp_q.pop_front();
      vectors++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, got}) begin
        miscompares++;
        $display("FAIL run_fetch%0d: got v=%0b pc=%h instr=%h, want pc=%h instr=%h",
                 k, if_valid, if_pc, if_instr, got[63:32], got[31:0]);
      end
    end
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if ({if_valid, if_pc, if_instr, imem_addr, fetch_cnt} !== {1'b1, 32'h8, mem[2], 7'h0C, 16'd2}) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got v=%0b pc=%h instr=%h addr=%h cnt=%0d, want pc=8 addr=0c cnt=2",
                 k, if_valid, if_pc, if_instr, imem_addr, fetch_cnt);
      end
    end
    id_ready = 1'b1;
    push_fetch(32'h0C);
    push_fetch(32'h10);
    for (int k = 0; k < 2; k++) begin
      tick();
      got = exp_q.pop_front();
      vectors++;
      if ({if_valid, if_pc, if_instr, fetch_cnt} !== {1'b1, got, 16'(3 + k)}) begin
        miscompares++;
        $display("FAIL stall_release%0d: got pc=%h instr=%h cnt=%0d, want pc=%h cnt=%0d",
                 k, if_pc, if_instr, fetch_cnt, got[63:32], 3 + k);
      end
    end
  endtask

  task automatic test_redirect_stalled();
    id_ready = 1'b0;
    tick();
    redir_valid = 1'b1;
    redir_pc = 32'h3A;
    tick();
    redir_valid = 1'b0;
    vectors++;
    if ({if_valid, fetch_cnt, imem_addr} !== {1'b0, 16'd4, 7'h38}) begin
      miscompares++;
      $display("FAIL redir_flush: got v=%0b cnt=%0d addr=%h, want v=0 cnt=4 addr=38",
               if_valid, fetch_cnt, imem_addr);
    end
    push_fetch(32'h38);
    tick();
    got = exp_q.pop_front();
    vectors++;
    if ({if_valid, if_pc, if_instr, fetch_cnt} !== {1'b1, got, 16'd4}) begin
      miscompares++;
      $display("FAIL redir_target: got v=%0b pc=%h instr=%h cnt=%0d, want pc=%h cnt=4",
               if_valid, if_pc, if_instr, fetch_cnt, got[63:32]);
    end
  endtask

  task automatic test_redirect_with_handshake();
    id_ready = 1'b1;
    redir_valid = 1'b1;
    redir_pc = 32'h04;
    tick();
    redir_valid = 1'b0;
    vectors++;
    if ({if_valid, fetch_cnt} !== {1'b0, 16'd5}) begin
      miscompares++;
      $display("FAIL redir_handshake: got v=%0b cnt=%0d, want v=0 cnt=5", if_valid, fetch_cnt);
    end
    push_fetch(32'h04);
    tick();
    got = exp_q.pop_front();
    vectors++;
    if ({if_valid, if_pc, if_instr, fetch_cnt} !== {1'b1, got, 16'd5}) begin
      miscompares++;
      $display("FAIL redir_handshake_target: got pc=%h instr=%h cnt=%0d, want pc=%h cnt=5",
               if_pc, if_instr, fetch_cnt, got[63:32]);
    end
  endtask

  task automatic test_reset_midrun();
    for (int k = 0; k < 6; k++) begin
      push_fetch(32'(8 + 4 * k));
      tick();
      got = exp_q.pop_front();
      vectors++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, got}) begin
        miscompares++;
        $display("FAIL midrun_fetch%0d: got pc=%h instr=%h, want pc=%h instr=%h",
                 k, if_pc, if_instr, got[63:32], got[31:0]);
      end
    end
    vectors++;
    if (imem_addr !== 7'h20) begin
      miscompares++;
      $display("FAIL midrun_addr: got %h, want 20", imem_addr);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({if_valid, if_instr, if_pc, halted, fetch_cnt, imem_addr} !== {1'b0, 32'h0, 32'h0, 1'b0, 16'h0, 7'h0}) begin
      miscompares++;
      $display("FAIL async_reset: got v=%0b instr=%h pc=%h halt=%0b cnt=%0d addr=%h, want all zero",
               if_valid, if_instr, if_pc, halted, fetch_cnt, imem_addr);
    end
    #1;
    reset = 1'b0;
  endtask

  task automatic test_bounds();
    for (int k = 0; k < 32; k++) begin
      push_fetch(32'(4 * k));
      tick();
      got = exp_q.pop_front();
      vectors++;
      if ({if_valid, if_pc, if_instr, halted} !== {1'b1, got, 1'b0}) begin
        miscompares++;
        $display("FAIL bounds_run%0d: got v=%0b pc=%h instr=%h halt=%0b, want pc=%h halt=0",
                 k, if_valid, if_pc, if_instr, halted, got[63:32]);
      end
    end
    vectors++;
    if (imem_addr !== 7'h00) begin
      miscompares++;
      $display("FAIL bounds_addr_wrap: got %h, want 00", imem_addr);
    end
`ifdef IFU_BOUNDS_CHECK_EN
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if ({halted, if_valid, fetch_cnt, imem_addr} !== {1'b1, 1'b0, 16'd32, 7'h00}) begin
        miscompares++;
        $display("FAIL bounds_halt%0d: got halt=%0b v=%0b cnt=%0d addr=%h, want halt=1 v=0 cnt=32 addr=00",
                 k, halted, if_valid, fetch_cnt, imem_addr);
      end
    end
    redir_valid = 1'b1;
    redir_pc = 32'h10;
    tick();
    redir_valid = 1'b0;
    vectors++;
    if ({halted, if_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL bounds_resume: got halt=%0b v=%0b, want 0 0", halted, if_valid);
    end
    push_fetch(32'h10);
    tick();
    got = exp_q.pop_front();
    vectors++;
    if ({if_valid, if_pc, if_instr, halted} !== {1'b1, got, 1'b0}) begin
      miscompares++;
      $display("FAIL bounds_resume_fetch: got v=%0b pc=%h instr=%h halt=%0b, want pc=10",
               if_valid, if_pc, if_instr, halted);
    end
`else
    exp_q.push_back({32'h80, mem[0]});
    tick();
    got = exp_q.pop_front();
    vectors++;
    if ({if_valid, if_pc, if_instr, halted, fetch_cnt} !== {1'b1, got, 1'b0, 16'd32}) begin
      miscompares++;
      $display("FAIL nobounds_wrap: got v=%0b pc=%h instr=%h halt=%0b cnt=%0d, want pc=80 halt=0 cnt=32",
               if_valid, if_pc, if_instr, halted, fetch_cnt);
    end
`endif
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 32; i++) mem[i] = $urandom_range(32'hFFFF_FFFF, 0);
    test_reset();
    test_run_and_stall();
    test_redirect_stalled();
    test_redirect_with_handshake();
    test_reset_midrun();
    test_bounds();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the 32-bit single-cycle RISC core. It owns the program counter and drives the byte address into the async-read instruction memory. It registers the returned instruction word into an IF output register with a valid/ready handshake toward decode. It also accepts PC redirects from branch/jump resolution.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `IMEM_ADDR_W`, default 7: width of the byte address driven to instruction memory.
- `IMEM_BYTES`, default 128: addressable instruction space in bytes (32 words).
- `CNT_W`, default 16: width of the delivered-instruction counter.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: reset, asynchronous, active-high.
- `imem_addr` out IMEM_ADDR_W: byte address to instruction memory, equal to `pc[IMEM_ADDR_W-1:0]`; combinational from the PC register.
- `imem_data` in 32: instruction word returned in the same cycle.
- `redir_valid` in 1: redirect request from branch/jump resolution.
- `redir_pc` in 32: redirect target; bits [1:0] are ignored and forced to 0.
- `if_valid` out 1: IF register holds a valid instruction.
- `if_instr` out 32: registered instruction.
- `if_pc` out 32: PC of `if_instr`.
- `id_ready` in 1: decode accepts the IF register this cycle.
- `halted` out 1: fetch stopped on a bounds fault.
- `fetch_cnt` out CNT_W: number of completed handshakes (`if_valid && id_ready`); wraps modulo 2^CNT_W.

## Operation
- States: `RUN` and `HALT`. Reset enters `RUN`.
- Reset values: `pc`=RESET_PC, `if_valid`=0, `if_instr`=0, `if_pc`=0, `halted`=0, `fetch_cnt`=0.
- Advance condition: `adv = !if_valid || id_ready`.
- Priority at each edge, highest first: reset > redirect > advance > hold.
- Redirect:
  - `pc <= {redir_pc[31:2],2'b0}`, `if_valid <= 0`.
  - Applies even while stalled. The in-flight IF instruction is flushed and not counted.
  - In `HALT`, a redirect returns the FSM to `RUN` and clears `halted`.
- Advance in `RUN`: `if_instr <= imem_data`, `if_pc <= pc`, `if_valid <= 1`, `pc <= pc + 4`. The adder is 32 bits and wraps.
- Hold (`if_valid && !id_ready`): `pc` and all IF outputs are unchanged; `imem_addr` stays stable.
- `fetch_cnt` increments on every handshake, including the handshake in the same cycle as a redirect.

## Timing
- `imem_addr` changes 0 cycles after a `pc` update (combinational).
- Fetch latency: an instruction at `pc` appears on `if_instr` one edge after `pc` is presented with `adv`=1.
- Redirect penalty: `if_valid`=0 for exactly one cycle after the redirect edge. The next edge delivers `redir_pc`.
- With `id_ready` held high, throughput is one instruction per cycle.
- Reset asserted mid-stall or mid-redirect clears everything immediately, without waiting for a clock edge.
- Simultaneous `redir_valid` and handshake: the handshake is counted, then the flush applies.

## Configuration
- Macro: `IFU_BOUNDS_CHECK_EN`.
- Defined:
  - On an advance with `pc >= IMEM_BYTES`, no fetch occurs. The FSM enters `HALT`, `halted` is set the same edge and `if_valid <= 0`; `pc` holds.
  - Only a redirect or reset leaves `HALT`.
- Undefined:
  - The `HALT` state is absent and `halted` is tied to 0.
  - `imem_addr` wraps naturally as `pc[IMEM_ADDR_W-1:0]`.

## Structure
- `ifu_pkg` holds:
  - the state enum `ifu_state_t` (`RUN`, `HALT`);
  - the constants `INSTR_W=32`, `PC_INC=4`, `DEFAULT_RESET_PC`, `DEFAULT_IMEM_BYTES`.
- One sub-module, `ifu_pc_reg`. It contains the PC register, the +4 adder, redirect alignment and the next-PC priority mux. The top level holds the FSM, IF register and counter.

## Test plan
- Reset, then release with `id_ready`=1 and IMEM preloaded: `if_pc` runs 0,4,8,12 on consecutive cycles; `if_instr` matches the words; `fetch_cnt`=4 after 4 handshakes.
- Stall: `id_ready`=0 for 3 cycles while `if_pc`=8. `if_pc`, `if_instr` and `imem_addr`=0x0C are held. After release, `if_pc`=0x0C on the next cycle; `fetch_cnt` does not advance during the stall.
- Redirect `redir_pc`=0x3A while stalled: one cycle with `if_valid`=0, then `if_pc`=0x38; the flushed instruction is not counted.
- Reset pulse mid-run at `pc`=0x20, asserted between clock edges: all outputs return to reset values immediately and `imem_addr`=0.
- With `IFU_BOUNDS_CHECK_EN`, free-run to `pc`=0x80: `halted`=1 and `if_valid`=0. A redirect to 0x10 resumes with `if_pc`=0x10 and `halted`=0.
- Without the macro, the same run gives `imem_addr`=0 at `pc`=0x80, `if_pc`=0x80 and `halted`=0 throughout.
